// File: rtl/serial_word_deser_if.sv
// Bundle of the serial input stream and the word output handshake for serial_word_deser.
// Optional macro PARITY_CHECK_EN adds the parity_err output.
interface serial_word_deser_if #(
    parameter int unsigned WIDTH = 8
);
    logic             d_valid;
    logic             d;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             sync_lock;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;

    // Deserializer side: consumes bits, produces words.
    modport master (
        input  d_valid, d, word_ready,
        output word_data, word_valid, sync_lock, overrun, parity_err
    );

    // Environment side: drives bits, takes words.
    modport slave (
        output d_valid, d, word_ready,
        input  word_data, word_valid, sync_lock, overrun, parity_err
    );
`else
    // Deserializer side: consumes bits, produces words.
    modport master (
        input  d_valid, d, word_ready,
        output word_data, word_valid, sync_lock, overrun
    );

    // Environment side: drives bits, takes words.
    modport slave (
        output d_valid, d, word_ready,
        input  word_data, word_valid, sync_lock, overrun
    );
`endif
endinterface

// File: rtl/serial_word_deser.sv
// Serial word deserializer: hunts for a sync pattern, shifts in WIDTH bits MSB-first and
// presents each word on a single-entry valid/ready register. A word that completes while
// the register is full and not being drained is dropped with a one-cycle overrun pulse.
// Optional macro PARITY_CHECK_EN: one even-parity bit follows the data bits and its
// result is reported on parity_err alongside the word.
module serial_word_deser #(
    parameter int unsigned          WIDTH    = 8,
    parameter int unsigned          SYNC_LEN = 8,
    parameter logic [SYNC_LEN-1:0]  SYNC_PAT = SYNC_LEN'(8'hA5)
) (
    input logic                  clk,
    input logic                  rst,
    serial_word_deser_if.master  bus
);
    localparam int unsigned CntW  = $clog2(WIDTH);
    localparam int unsigned FillW = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {StHunt, StCollect, StParity} state_e;

    state_e              state_q, state_d;
    logic [SYNC_LEN-1:0] hist_q, hist_d;
    logic [FillW-1:0]    fill_q, fill_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic [SYNC_LEN-1:0] hist_shift;
    logic [WIDTH-1:0]    shreg_shift;
    logic                complete;
    logic [WIDTH-1:0]    done_word;
`ifdef PARITY_CHECK_EN
    logic                par_q, par_d;
    logic                perr_q, perr_d;
    logic                done_perr;
`endif

    assign hist_shift  = {hist_q[SYNC_LEN-2:0], bus.d};
    assign shreg_shift = {shreg_q[WIDTH-2:0], bus.d};

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StHunt;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Next-state: sync hunt, bit collection and output register load/drop.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        complete  = 1'b0;
        done_word = shreg_q;
`ifdef PARITY_CHECK_EN
        par_d     = par_q;
        perr_d    = perr_q;
        done_perr = 1'b0;
`endif

        unique case (state_q)
            StHunt: begin
                if (bus.d_valid) begin
                    hist_d = hist_shift;
                    if (fill_q != FillW'(SYNC_LEN)) fill_d = fill_q + 1'b1;
                    // Fill count after this bit must be full, so reset zeros never match.
                    if ((fill_q >= FillW'(SYNC_LEN - 1)) && (hist_shift == SYNC_PAT)) begin
                        state_d = StCollect;
                        fill_d  = '0;
                        cnt_d   = '0;
`ifdef PARITY_CHECK_EN
                        par_d   = 1'b0;
`endif
                    end
                end
            end
            StCollect: begin
                if (bus.d_valid) begin
                    shreg_d = shreg_shift;
                    cnt_d   = cnt_q + 1'b1;
`ifdef PARITY_CHECK_EN
                    par_d   = par_q ^ bus.d;
                    if (cnt_q == CntW'(WIDTH - 1)) state_d = StParity;
`else
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d   = StHunt;
                        complete  = 1'b1;
                        done_word = shreg_shift;
                    end
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            StParity: begin
                if (bus.d_valid) begin
                    state_d   = StHunt;
                    complete  = 1'b1;
                    done_word = shreg_q;
                    done_perr = par_q ^ bus.d;
                end
            end
`endif
            default: state_d = StHunt;
        endcase

        if (valid_q && bus.word_ready) valid_d = 1'b0;

        // A word drained on this same edge frees the register for the new word.
        if (complete) begin
            if (!valid_q || bus.word_ready) begin
                data_d  = done_word;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = done_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.word_data  = data_q;
    assign bus.word_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.sync_lock  = (state_q == StCollect) || (state_q == StParity);
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_serial_word_deser.sv
// Bench for serial_word_deser: bit-queue model checked every cycle plus directed
// literal expectations. Supports builds with and without PARITY_CHECK_EN.
module tb_serial_word_deser;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned SYNC_LEN = 8;
    localparam logic [7:0]  SYNC_PAT = 8'hA5;
`ifdef PARITY_CHECK_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_word_deser_if #(.WIDTH(WIDTH)) bus ();

    serial_word_deser #(
        .WIDTH    (WIDTH),
        .SYNC_LEN (SYNC_LEN),
        .SYNC_PAT (SYNC_PAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bit history queue while hunting, plain accumulator while locked.
    bit               m_hist[$];
    bit               m_lock;
    int               m_nbits;
    int               m_ones;
    logic [31:0]      m_acc;
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    bit               m_ovr;
    bit               m_perr;
    logic [WIDTH-1:0] xfer_log[$];
    int               lock_cycles = 0;
    int               ovr_count   = 0;

    function automatic bit hist_matches();
        logic [SYNC_LEN-1:0] pat;
        pat = SYNC_PAT;
        for (int i = 0; i < SYNC_LEN; i++)
            if (m_hist[i] != pat[SYNC_LEN-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_lock  = 0;
        m_nbits = 0;
        m_ones  = 0;
        m_acc   = 0;
        m_data  = '0;
        m_valid = 0;
        m_ovr   = 0;
        m_perr  = 0;
    endtask

    task automatic model_step();
        bit               complete;
        bit               xfer;
        logic [WIDTH-1:0] nw;
        bit               np;
        complete = 0;
        nw       = '0;
        np       = 0;
        xfer     = m_valid && bus.word_ready;
        if (xfer) xfer_log.push_back(m_data);
        m_ovr = 0;
        if (bus.d_valid) begin
            if (!m_lock) begin
                m_hist.push_back(bus.d);
                if (m_hist.size() > SYNC_LEN) void'(m_hist.pop_front());
                if (m_hist.size() == SYNC_LEN && hist_matches()) begin
                    m_lock  = 1;
                    m_hist.delete();
                    m_nbits = 0;
                    m_acc   = 0;
                    m_ones  = 0;
                end
            end else begin
                if (m_nbits < WIDTH) m_acc = (m_acc << 1) | 32'(bus.d);
                m_ones  += int'(bus.d);
                m_nbits++;
                if (m_nbits == WIDTH + PAR_BITS) begin
                    complete = 1;
                    nw       = m_acc[WIDTH-1:0];
                    np       = (m_ones % 2) != 0;
                    m_lock   = 0;
                end
            end
        end
        if (xfer) m_valid = 0;
        if (complete) begin
            if (!m_valid) begin
                m_data  = nw;
                m_valid = 1;
                m_perr  = np;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    // Model update on each edge / reset, then compare shortly after.
    always begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else model_step();
        #1;
        check("word_data", 32'(bus.word_data), 32'(m_data));
        check("word_valid", 32'(bus.word_valid), 32'(m_valid));
        check("sync_lock", 32'(bus.sync_lock), 32'(m_lock));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
`ifdef PARITY_CHECK_EN
        check("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
        if (bus.sync_lock) lock_cycles++;
        if (bus.overrun) ovr_count++;
    end

    task automatic drive_bit(input bit b, input bit gap, input bit set_rdy);
        @(negedge clk);
        bus.d_valid = 1'b1;
        bus.d       = b;
        if (set_rdy) bus.word_ready = 1'b1;
        if (gap) begin
            @(negedge clk);
            bus.d_valid = 1'b0;
            if (set_rdy) bus.word_ready = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) drive_bit(v[i], gap, 1'b0);
    endtask

    // Sync + data (+ parity); returns at the negedge after the last bit was sampled.
    task automatic send_frame(input logic [7:0] v, input bit gap, input bit flip,
                              input bit rdy_last);
        send_byte(SYNC_PAT, gap);
        for (int i = WIDTH - 1; i >= 0; i--)
            drive_bit(v[i], gap, rdy_last && (PAR_BITS == 0) && (i == 0));
`ifdef PARITY_CHECK_EN
        drive_bit((^v) ^ flip, gap, rdy_last);
`endif
        if (!gap) begin
            @(negedge clk);
            bus.d_valid = 1'b0;
            if (rdy_last) bus.word_ready = 1'b0;
        end
    endtask

    task automatic drain();
        bus.word_ready = 1'b1;
        @(negedge clk);
        bus.word_ready = 1'b0;
    endtask

    initial begin
        bus.d_valid    = 1'b0;
        bus.d          = 1'b0;
        bus.word_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 32'(bus.word_valid), 32'h0);
        check("rst_data", 32'(bus.word_data), 32'h0);
        check("rst_lock", 32'(bus.sync_lock), 32'h0);
        check("rst_ovr", 32'(bus.overrun), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-collect with a held word.
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        check("t1_held", 32'(bus.word_data), 32'h77);
        check("t1_model_held", 32'(m_data), 32'h77);
        send_byte(SYNC_PAT, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.d_valid = 1'b0;
        check("t1_lock_mid", 32'(bus.sync_lock), 32'h1);
        #2 rst = 1'b1;
        #2;
        check("t1_rst_valid", 32'(bus.word_valid), 32'h0);
        check("t1_rst_data", 32'(bus.word_data), 32'h0);
        check("t1_rst_lock", 32'(bus.sync_lock), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("t1_pre_valid", 32'(bus.word_valid), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t1_word", 32'(bus.word_data), 32'h3C);
        check("t1_valid", 32'(bus.word_valid), 32'h1);
        check("t1_model_word", 32'(m_data), 32'h3C);
        drain();
        check("t1_drained", 32'(bus.word_valid), 32'h0);

        // Sync hunt through decoy bytes.
        bus.word_ready = 1'b1;
        xfer_log.delete();
        lock_cycles = 0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        check("t2_no_early_lock", 32'(lock_cycles), 32'h0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.word_ready = 1'b0;
        check("t2_nwords", 32'(xfer_log.size()), 32'h1);
        if (xfer_log.size() > 0) check("t2_word", 32'(xfer_log[0]), 32'hC3);
        check("t2_lock_cycles", 32'(lock_cycles), 32'(WIDTH + PAR_BITS));

        // Gapped input.
        bus.word_ready = 1'b1;
        xfer_log.delete();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.word_ready = 1'b0;
        check("t3_nwords", 32'(xfer_log.size()), 32'h1);
        if (xfer_log.size() > 0) check("t3_word", 32'(xfer_log[0]), 32'h81);

        // Backpressure: second word dropped.
        ovr_count = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t4_held", 32'(bus.word_data), 32'h11);
        check("t4_valid", 32'(bus.word_valid), 32'h1);
        check("t4_ovr_count", 32'(ovr_count), 32'h1);
        xfer_log.delete();
        drain();
        check("t4_drained", 32'(bus.word_valid), 32'h0);
        check("t4_nwords", 32'(xfer_log.size()), 32'h1);
        if (xfer_log.size() > 0) check("t4_word", 32'(xfer_log[0]), 32'h11);

        // Accept-and-replace on the same edge.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        ovr_count = 0;
        xfer_log.delete();
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("t5_word", 32'(bus.word_data), 32'h22);
        check("t5_valid", 32'(bus.word_valid), 32'h1);
        check("t5_ovr_count", 32'(ovr_count), 32'h0);
        check("t5_nwords", 32'(xfer_log.size()), 32'h1);
        if (xfer_log.size() > 0) check("t5_xfer", 32'(xfer_log[0]), 32'h11);
        drain();

`ifdef PARITY_CHECK_EN
        send_frame(8'h03, 1'b0, 1'b0, 1'b0);
        check("t6_perr_ok", 32'(bus.parity_err), 32'h0);
        check("t6_word_ok", 32'(bus.word_data), 32'h03);
        drain();
        send_frame(8'h03, 1'b0, 1'b1, 1'b0);
        check("t6_perr_bad", 32'(bus.parity_err), 32'h1);
        check("t6_valid_bad", 32'(bus.word_valid), 32'h1);
        check("t6_model_perr", 32'(m_perr), 32'h1);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
